// File: rtl/axil_reg_slave.sv
// AXI4-Lite register responder: RW control bank followed by RO status bank.
// Optional macro AXIL_CMD_SELF_CLEAR_EN turns control register 0 into a self-clearing command register.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_NUM   = 8,
  parameter int STS_NUM    = 8
) (
  input  logic                           axil_clk,
  input  logic                           axil_rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [CTRL_NUM*DATA_WIDTH-1:0] ctrl_out,
  output logic [CTRL_NUM-1:0]            ctrl_wr_pulse,
  input  logic [STS_NUM*DATA_WIDTH-1:0]  sts_in
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    MAP_CTRL,
    MAP_STS,
    MAP_NONE
  } map_e;

  function automatic map_e decode(input logic [31:0] idx);
    if (idx < CTRL_NUM) return MAP_CTRL;
    if (idx < CTRL_NUM + STS_NUM) return MAP_STS;
    return MAP_NONE;
  endfunction

  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [IDX_W-1:0]      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] ctrl_q [CTRL_NUM];
  logic [DATA_WIDTH-1:0] ctrl_d [CTRL_NUM];
  logic [CTRL_NUM-1:0]   pulse_q, pulse_d;

  logic                  aw_fire, w_fire, commit, ar_fire;
  logic [31:0]           cmt_idx, rd_idx;
  logic [DATA_WIDTH-1:0] cmt_data;
  logic [STRB_W-1:0]     cmt_strb;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Commit uses the held AW/W beat when present, otherwise the one arriving this cycle.
  always_comb begin
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awidx_d  = awidx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    ctrl_d   = ctrl_q;
    pulse_d  = '0;
`ifdef AXIL_CMD_SELF_CLEAR_EN
    ctrl_d[0] = '0;
`endif
    aw_fire  = s_axil_awvalid & ~aw_got_q;
    w_fire   = s_axil_wvalid & ~w_got_q;
    cmt_idx  = aw_got_q ? 32'(awidx_q) : 32'(s_axil_awaddr[ADDR_WIDTH-1:2]);
    cmt_data = w_got_q ? wdata_q : s_axil_wdata;
    cmt_strb = w_got_q ? wstrb_q : s_axil_wstrb;
    commit   = (aw_got_q | s_axil_awvalid) & (w_got_q | s_axil_wvalid) & ~bvalid_q;

    if (aw_fire) begin
      aw_got_d = 1'b1;
      awidx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
    end
    if (w_fire) begin
      w_got_d = 1'b1;
      wdata_d = s_axil_wdata;
      wstrb_d = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      case (decode(cmt_idx))
        MAP_CTRL: begin
          bresp_d = RESP_OKAY;
          for (int i = 0; i < CTRL_NUM; i++) begin
            if (cmt_idx == 32'(i)) begin
              pulse_d[i] = 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (cmt_strb[b]) ctrl_d[i][b*8 +: 8] = cmt_data[b*8 +: 8];
              end
            end
          end
        end
        MAP_STS: bresp_d = RESP_SLVERR;
        default: bresp_d = RESP_DECERR;
      endcase
    end
  end

  // Read data is captured from the pre-commit register state in the AR cycle.
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ar_fire   = s_axil_arvalid & arready_q;
    rd_idx    = 32'(s_axil_araddr[ADDR_WIDTH-1:2]);

    if (rvalid_q && s_axil_rready) begin
      rvalid_d  = 1'b0;
      arready_d = 1'b1;
    end
    if (ar_fire) begin
      arready_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = '0;
      rresp_d   = (decode(rd_idx) == MAP_NONE) ? RESP_DECERR : RESP_OKAY;
      for (int i = 0; i < CTRL_NUM; i++) begin
        if (rd_idx == 32'(i)) rdata_d = ctrl_q[i];
      end
`ifdef AXIL_CMD_SELF_CLEAR_EN
      if (rd_idx == 32'd0) rdata_d = '0;
`endif
      for (int j = 0; j < STS_NUM; j++) begin
        if (rd_idx == 32'(CTRL_NUM + j)) rdata_d = sts_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge axil_clk or negedge axil_rst_n) begin
    if (!axil_rst_n) begin
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int i = 0; i < CTRL_NUM; i++) ctrl_q[i] <= '0;
    end else begin
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < CTRL_NUM; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

  assign s_axil_awready = ~aw_got_q;
  assign s_axil_wready  = ~w_got_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign ctrl_wr_pulse  = pulse_q;

  for (genvar g = 0; g < CTRL_NUM; g++) begin : g_ctrl_out
    assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end

endmodule
